// File: rtl/clk_mon.sv
// Period/high-time monitor for an asynchronous signal sampled on clk_i.
// It also tracks frequency lock against EXP_PERIOD and flags a missing signal with a timeout.
module clk_mon #(
  parameter int CNTW       = 16,
  parameter int EXP_PERIOD = 6,
  parameter int TOL        = 0,
  parameter int LOCKN      = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            sig_i,
  input  logic            en_i,
  output logic [CNTW-1:0] period_o,
  output logic [CNTW-1:0] high_o,
  output logic            valid_o,
  output logic            locked_o,
  output logic            err_o,
  output logic            timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;

  localparam logic [CNTW-1:0] CMAX     = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] TMO      = CNTW'(TIMEOUT);
  localparam logic [CNTW:0]   EXP_X    = (CNTW+1)'(EXP_PERIOD);
  localparam logic [CNTW:0]   TOL_X    = (CNTW+1)'(TOL);
  localparam logic [3:0]      LOCK_MAX = 4'(LOCKN);

  // A timeout at or above the saturation value could never be observed.
  if (TIMEOUT >= (2**CNTW) - 1) begin : g_bad_timeout
    $error("clk_mon: TIMEOUT must be below 2**CNTW-1");
  end
  if (LOCKN < 1 || LOCKN > 15) begin : g_bad_lockn
    $error("clk_mon: LOCKN must be within 1..15");
  end

  logic            sync1_q, sync2_q, hist_q;
  logic            rise;
  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
  logic [CNTW-1:0] period_q, period_d, high_q, high_d;
  logic [3:0]      lcnt_q, lcnt_d, lcnt_inc;
  logic            valid_q, valid_d, locked_q, locked_d;
  logic            err_q, err_d, tmo_q, tmo_d;
  logic [CNTW-1:0] pcnt_inc, hcnt_inc;
  logic [CNTW:0]   pcnt_x, dev;
  logic            in_tol, tmo_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~hist_q;

  assign pcnt_inc = (pcnt_q == CMAX) ? pcnt_q : pcnt_q + 1'b1;
  assign hcnt_inc = (hcnt_q == CMAX) ? hcnt_q : hcnt_q + 1'b1;
  assign lcnt_inc = (lcnt_q >= LOCK_MAX) ? LOCK_MAX : lcnt_q + 4'd1;

  // Deviation is taken one bit wider so the subtraction cannot wrap.
  assign pcnt_x  = {1'b0, pcnt_q};
  assign dev     = (pcnt_x >= EXP_X) ? pcnt_x - EXP_X : EXP_X - pcnt_x;
  assign in_tol  = (dev <= TOL_X);
  assign tmo_hit = (pcnt_q >= TMO);

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    lcnt_d   = lcnt_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    tmo_d    = 1'b0;
    if (!en_i) begin
      state_d  = S_IDLE;
      pcnt_d   = '0;
      hcnt_d   = '0;
      lcnt_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          pcnt_d  = {{(CNTW-1){1'b0}}, 1'b1};
          hcnt_d  = '0;
        end
        S_ARM, S_MEAS: begin
          if (rise) begin
            state_d = S_MEAS;
            pcnt_d  = {{(CNTW-1){1'b0}}, 1'b1};
            hcnt_d  = {{(CNTW-1){1'b0}}, 1'b1};
            if (state_q == S_MEAS) begin
              period_d = pcnt_q;
              high_d   = hcnt_q;
              valid_d  = 1'b1;
              if (in_tol) begin
                lcnt_d   = lcnt_inc;
                locked_d = (lcnt_inc == LOCK_MAX);
              end else begin
                err_d    = locked_q;
                lcnt_d   = '0;
                locked_d = 1'b0;
              end
            end
          end else if (tmo_hit) begin
            // Restart arming; the next rise only re-arms the measurement.
            state_d  = S_ARM;
            pcnt_d   = {{(CNTW-1){1'b0}}, 1'b1};
            hcnt_d   = '0;
            tmo_d    = 1'b1;
            err_d    = locked_q;
            lcnt_d   = '0;
            locked_d = 1'b0;
          end else begin
            pcnt_d = pcnt_inc;
            if (state_q == S_MEAS && sync2_q) hcnt_d = hcnt_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      lcnt_q   <= '0;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      lcnt_q   <= lcnt_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign timeout_o = tmo_q;

endmodule

// File: doc/clk_mon.md
CLK_MON -- requirements
Module: clk_mon

Parameters
REQ-001 CNTW, default 16, width of all period/high counters and outputs.
REQ-002 EXP_PERIOD, default 6, expected sig_i period in clk_i cycles.
REQ-003 TOL, default 0, allowed absolute deviation from EXP_PERIOD, in clk_i cycles.
REQ-004 LOCKN, default 4, number of consecutive in-tolerance periods required to lock (1..15).
REQ-005 TIMEOUT, default 1000, cycle count without a rising edge that aborts a measurement (< 2^CNTW-1).

Interface
REQ-006 clk_i  input  1  system clock; all flops on its rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 sig_i  input  1  asynchronous clock/signal under test, e.g. a divided clock.
REQ-009 en_i  input  1  measurement enable, synchronous to clk_i.
REQ-010 period_o  output  CNTW  last measured period, in clk_i cycles.
REQ-011 high_o  output  CNTW  last measured high time, in clk_i cycles.
REQ-012 valid_o  output  1  one-cycle pulse when period_o/high_o update.
REQ-013 locked_o  output  1  level; sig_i period within tolerance for LOCKN consecutive periods.
REQ-014 err_o  output  1  one-cycle pulse on an out-of-tolerance period or timeout while locked.
REQ-015 timeout_o  output  1  one-cycle pulse when TIMEOUT expires.

Function
REQ-016 sig_i SHALL pass through a 2-flop synchronizer plus 1 history flop; rise = sync2 & ~hist, fall = ~sync2 & hist.
REQ-017 Latency from a sig_i transition to the rise/fall detect cycle SHALL be 2 clk_i cycles when setup is met.
REQ-018 FSM states SHALL be IDLE, ARM, MEAS; reset state is IDLE.
REQ-019 IDLE -> ARM when en_i=1; any state -> IDLE in the next cycle when en_i=0.
REQ-020 ARM: wait for rise; on rise load pcnt=1, hcnt=1, go to MEAS; falls are ignored.
REQ-021 MEAS: pcnt increments each cycle without rise; hcnt increments while sync2=1; hcnt freezes on fall.
REQ-022 On rise in MEAS: period_o<=pcnt, high_o<=hcnt, valid_o=1 next cycle, then pcnt<=1, hcnt<=1, stay in MEAS.
REQ-023 Counters SHALL saturate at 2^CNTW-1, never wrap.
REQ-024 In-tolerance test: |pcnt-EXP_PERIOD| <= TOL, evaluated at each rise in MEAS, computed at CNTW+1 bits with no overflow.
REQ-025 A lock counter SHALL increment on each in-tolerance period (saturating at LOCKN), clear on an out-of-tolerance period, and set locked_o when it reaches LOCKN.
REQ-026 Out-of-tolerance period while locked_o=1: locked_o<=0, err_o pulse, period_o/valid_o still update.
REQ-027 pcnt reaching TIMEOUT in ARM or MEAS without rise: timeout_o pulse; err_o pulse if locked; locked_o<=0; lock counter<=0; state->ARM; period_o/high_o hold.
REQ-028 If rise and en_i=0 occur in the same cycle, en_i wins: no valid_o, state->IDLE.
REQ-029 Leaving MEAS via en_i=0 SHALL clear locked_o and the lock counter and hold period_o/high_o; no err_o.
REQ-030 valid_o, err_o and timeout_o SHALL each be high for exactly one cycle per event and never in IDLE.

Reset
REQ-031 rst_i=1 SHALL immediately force: period_o=0, high_o=0, valid_o=0, locked_o=0, err_o=0, timeout_o=0, state=IDLE, all counters and synchronizer flops=0.
REQ-032 After rst_i falls, the first rise SHALL only arm (ARM->MEAS); the first valid_o follows the second rise.
REQ-033 rst_i asserted mid-measurement SHALL discard the partial count; no valid_o is produced for it.

Verification
REQ-034 en_i=1, sig_i toggling every 3 clk_i cycles -> valid_o each 6 cycles, period_o=6, high_o=3; locked_o=1 after the 4th valid_o.
REQ-035 Locked, one period stretched to 8 cycles (TOL=0) -> that valid_o shows period_o=8 with err_o pulse in the same cycle; locked_o=0; relock after 4 good periods.
REQ-036 Locked, sig_i held low 1000 cycles -> timeout_o and err_o pulse, locked_o=0, state ARM, period_o holds 6.
REQ-037 en_i dropped mid-period, coinciding with a rise -> no valid_o, locked_o=0, outputs hold; re-enable -> first valid_o on the second rise.
REQ-038 rst_i pulsed asynchronously between clock edges while locked -> all outputs 0 before the next clk_i edge; normal operation after release.
REQ-039 CNTW=4, TIMEOUT above counter max disallowed; CNTW=4, TIMEOUT=14, sig_i period 20 -> timeout at pcnt=14, no wrap observed.
